// File: rtl/mem_arbiter.sv
// Three-requester memory arbiter: N64 priority with a burst cap, CPU/DMA round-robin.
// Optional ack watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W         = 26,
    parameter int N64_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            write,
    input  logic [3*ADDR_W-1:0]   address,
    input  logic [47:0]           wdata,
    output logic [2:0]            ack,
    output logic [15:0]           rdata,
    output logic                  mem_request,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rdata,
    output logic [1:0]            grant_id,
    output logic                  error,
    input  logic                  error_clear
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int STREAK_W = $clog2(N64_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(N64_BURST);

    state_t              state_reg, state_next;
    logic [1:0]          win_reg, win_next, winner;
    logic                rr_ptr_reg, rr_ptr_next;
    logic [STREAK_W-1:0] streak_reg, streak_next;
    logic [2:0]          ack_reg, ack_next;
    logic [15:0]         rdata_reg, rdata_next;
    logic                mem_request_reg, mem_request_next;
    logic                mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0]   mem_address_reg, mem_address_next;
    logic [15:0]         mem_wdata_reg, mem_wdata_next;

    logic [ADDR_W-1:0]   addr_slice [3];
    logic [15:0]         wdata_slice [3];
    logic                other_req, n64_blocked, grant, complete, timeout, done;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            assign addr_slice[gi]  = address[gi*ADDR_W +: ADDR_W];
            assign wdata_slice[gi] = wdata[gi*16 +: 16];
            assign ack_next[gi]    = done && (win_reg == 2'(gi));
        end
    endgenerate

    assign other_req = |req[2:1];
    assign grant     = (state_reg == ST_IDLE) && (|req);
    assign complete  = (state_reg == ST_WAIT) && mem_ack;
    assign done      = complete || timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             error_reg;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle that has no mem_ack.
    assign timeout = (state_reg == ST_WAIT) && !mem_ack &&
                     (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            else
                wait_cnt_reg <= '0;
            if (timeout)
                error_reg <= 1'b1;
            else if (error_clear)
                error_reg <= 1'b0;
        end
    end

    assign error = error_reg;
`else
    logic unused_cfg;
    assign unused_cfg = error_clear | (TIMEOUT_CYCLES == 0);
    assign timeout    = 1'b0;
    assign error      = 1'b0;
`endif

    // N64 wins unless its streak is capped while CPU/DMA are waiting.
    always_comb begin : win_sel
        n64_blocked = other_req && (streak_reg == STREAK_MAX);
        winner      = 2'd0;
        if (req[0] && !n64_blocked)
            winner = 2'd0;
        else if (req[1] && req[2])
            winner = rr_ptr_reg ? 2'd2 : 2'd1;
        else if (req[1])
            winner = 2'd1;
        else if (req[2])
            winner = 2'd2;
    end

    always_ff @(posedge clk) begin : state_reg_p
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin : next_state_p
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin : output_p
        mem_request_next = (state_next == ST_ISSUE) || (state_next == ST_WAIT);
        mem_write_next   = mem_write_reg;
        mem_address_next = mem_address_reg;
        mem_wdata_next   = mem_wdata_reg;
        win_next         = win_reg;
        rr_ptr_next      = rr_ptr_reg;
        streak_next      = streak_reg;
        rdata_next       = rdata_reg;

        if (grant) begin
            win_next         = winner;
            mem_write_next   = write[winner];
            mem_address_next = addr_slice[winner];
            mem_wdata_next   = wdata_slice[winner];
        end

        if (grant && winner != 2'd0) begin
            streak_next = '0;
            rr_ptr_next = ~rr_ptr_reg;
        end else if (!other_req) begin
            streak_next = '0;
        end else if (grant && streak_reg != STREAK_MAX) begin
            streak_next = streak_reg + 1'b1;
        end

        if (complete)
            rdata_next = mem_rdata;
        else if (timeout)
            rdata_next = 16'hFFFF;

        grant_id = ((state_reg != ST_IDLE) || (|ack_reg)) ? win_reg : 2'd3;
    end

    always_ff @(posedge clk) begin : datapath_p
        if (reset) begin
            win_reg         <= 2'd0;
            rr_ptr_reg      <= 1'b0;
            streak_reg      <= '0;
            ack_reg         <= 3'b000;
            rdata_reg       <= 16'h0000;
            mem_request_reg <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= 16'h0000;
        end else begin
            win_reg         <= win_next;
            rr_ptr_reg      <= rr_ptr_next;
            streak_reg      <= streak_next;
            ack_reg         <= ack_next;
            rdata_reg       <= rdata_next;
            mem_request_reg <= mem_request_next;
            mem_write_reg   <= mem_write_next;
            mem_address_reg <= mem_address_next;
            mem_wdata_reg   <= mem_wdata_next;
        end
    end

    assign ack         = ack_reg;
    assign rdata       = rdata_reg;
    assign mem_request = mem_request_reg;
    assign mem_write   = mem_write_reg;
    assign mem_address = mem_address_reg;
    assign mem_wdata   = mem_wdata_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, meaning byte-address width of each request.
REQ-002 SHALL have parameter N64_BURST, default 4, meaning max consecutive requester-0 grants while another requester waits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning memory-ack watchdog limit; used only with MEM_ARB_TIMEOUT_EN.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  3  per-requester request; bit 0 = N64, bit 1 = CPU, bit 2 = DMA.
REQ-007 write  input  3  per-requester write flag.
REQ-008 address  input  3*ADDR_W  per-requester address, requester n in slice n.
REQ-009 wdata  input  48  per-requester 16-bit write data, requester n in slice n.
REQ-010 ack  output  3  per-requester one-cycle completion pulse.
REQ-011 rdata  output  16  read data, valid in the cycle its ack bit is high.
REQ-012 mem_request / mem_write  output  1 each  downstream request and direction.
REQ-013 mem_address  output  ADDR_W; mem_wdata  output  16  downstream address and data.
REQ-014 mem_ack  input  1; mem_rdata  input  16  downstream completion and read data.
REQ-015 grant_id  output  2  index of active requester, 3 when idle.
REQ-016 error  output  1; error_clear  input  1  sticky timeout flag and its clear.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT.
- IDLE: no req -> stay; any req -> latch winner's write/address/wdata, go ISSUE.
- ISSUE: mem_request=1 for exactly this cycle's registered output; go WAIT.
- WAIT: mem_request held 1 until mem_ack; on mem_ack capture mem_rdata, go IDLE.
REQ-018 Winner selection SHALL be: req[0] wins unless the N64 streak counter equals N64_BURST and req[2:1] is non-zero; otherwise round-robin between CPU and DMA, pointer toggling after every CPU/DMA grant, starting at CPU after reset.
REQ-019 N64 streak counter SHALL increment on each N64 grant made while req[2:1]!=0, reset to 0 on any CPU/DMA grant or when req[2:1]==0, and saturate at N64_BURST.
REQ-020 ack[g] SHALL pulse exactly one cycle, the cycle after mem_ack is sampled; rdata SHALL equal the captured mem_rdata in that cycle and hold until the next capture.
REQ-021 Minimum latency: req sampled in IDLE at cycle N -> mem_request high at N+1; mem_ack at cycle M -> ack at M+1; arbiter back in IDLE at M+1, so the next grant can issue at M+2.
REQ-022 Deasserting req[g] after grant SHALL NOT abort the transaction; it completes and ack[g] still pulses.
REQ-023 Requests arriving during ISSUE/WAIT SHALL be held off (no ack) until arbitration in IDLE.
REQ-024 mem_ack while in IDLE or ISSUE SHALL be ignored.
REQ-025 grant_id SHALL be the latched winner in ISSUE/WAIT and the cycle of ack, else 3.

Reset
REQ-026 On reset: state IDLE, ack=0, rdata=0, mem_request=0, mem_write=0, mem_address=0, mem_wdata=0, grant_id=3, error=0, streak=0, round-robin pointer=CPU.
REQ-027 Reset mid-transaction SHALL drop mem_request the next cycle and issue no ack.

Configuration
REQ-028 With MEM_ARB_TIMEOUT_EN defined: WAIT counts cycles; on reaching TIMEOUT_CYCLES without mem_ack, SHALL deassert mem_request, pulse ack[g] with rdata=16'hFFFF, set error, and return to IDLE; error_clear clears error; a set and a clear in the same cycle leave error=1.
REQ-029 Without MEM_ARB_TIMEOUT_EN: no counter; WAIT lasts indefinitely; error tied 0; error_clear ignored.

Verification
REQ-030 Single CPU read addr 0x100, mem_ack 3 cycles after request, mem_rdata 0xBEEF -> ack=3'b010 one cycle, rdata=0xBEEF, grant_id=1 during the transaction.
REQ-031 req=3'b111 held for 8 grants with immediate mem_ack -> order N64,N64,N64,N64,CPU,N64,N64,N64,... (N64_BURST=4).
REQ-032 req=3'b110 held for 4 grants -> CPU,DMA,CPU,DMA.
REQ-033 N64 write, req[0] dropped one cycle after grant -> write completes, ack[0] pulses once, mem_write=1 throughout.
REQ-034 reset asserted in WAIT -> mem_request=0 next cycle, no ack, grant_id=3.
REQ-035 MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no mem_ack -> ack pulse with rdata=0xFFFF after 16 WAIT cycles, error=1 until error_clear.
